// File: rtl/room_thermal_model.sv
// Room plant model driven by thermostat heating/cooling demands; produces the room temperature.
// Optional macro THERMAL_NOISE_EN adds an LFSR that randomly drops step events.
module room_thermal_model #(
  parameter int TEMP_W    = 5,
  parameter int INIT_TEMP = 19,
  parameter int AMBIENT   = 15,
  parameter int HEAT_DIV  = 4,
  parameter int COOL_DIV  = 3,
  parameter int DRIFT_DIV = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              heating,
  input  logic              cooling,
  input  logic              load_en,
  input  logic [TEMP_W-1:0] load_temp,
  output logic [TEMP_W-1:0] temperature,
  output logic              temp_valid,
  output logic              fault
);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_HEAT  = 2'd1,
    MODE_COOL  = 2'd2,
    MODE_FAULT = 2'd3
  } mode_t;

  localparam int MAX_HC  = (HEAT_DIV > COOL_DIV) ? HEAT_DIV : COOL_DIV;
  localparam int MAX_DIV = (MAX_HC > DRIFT_DIV) ? MAX_HC : DRIFT_DIV;
  localparam int PRESC_W = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  localparam logic [TEMP_W:0]   AMBIENT_X  = (TEMP_W+1)'(AMBIENT);
  localparam logic [TEMP_W:0]   ONE_X      = (TEMP_W+1)'(1);
  localparam logic [PRESC_W-1:0] HEAT_LAST  = PRESC_W'(HEAT_DIV - 1);
  localparam logic [PRESC_W-1:0] COOL_LAST  = PRESC_W'(COOL_DIV - 1);
  localparam logic [PRESC_W-1:0] DRIFT_LAST = PRESC_W'(DRIFT_DIV - 1);

  mode_t              r_mode;
  logic [PRESC_W-1:0] r_presc;
  logic [TEMP_W-1:0]  r_temp;
  logic               r_temp_valid;
  logic               r_fault;

  mode_t              w_mode_next;
  logic               w_mode_change;
  logic [PRESC_W-1:0] w_div_last;
  logic               w_step_due;
  logic               w_step_apply;
  logic               w_noise_block;
  logic [TEMP_W:0]    w_temp_x;
  logic [TEMP_W:0]    w_sum_x;
  logic [TEMP_W:0]    w_dif_x;
  logic [TEMP_W-1:0]  w_temp_up;
  logic [TEMP_W-1:0]  w_temp_dn;
  logic [TEMP_W-1:0]  w_step_temp;
  logic [TEMP_W-1:0]  w_temp_next;
  logic [PRESC_W-1:0] w_presc_next;

  always_comb begin
    w_mode_next = MODE_IDLE;
    case ({heating, cooling})
      2'b10:   w_mode_next = MODE_HEAT;
      2'b01:   w_mode_next = MODE_COOL;
      2'b11:   w_mode_next = MODE_FAULT;
      default: w_mode_next = MODE_IDLE;
    endcase
  end

  assign w_mode_change = (w_mode_next != r_mode);

  always_comb begin
    w_div_last = DRIFT_LAST;
    case (r_mode)
      MODE_HEAT: w_div_last = HEAT_LAST;
      MODE_COOL: w_div_last = COOL_LAST;
      default:   w_div_last = DRIFT_LAST;
    endcase
  end

  assign w_step_due   = (r_mode != MODE_FAULT) && (r_presc == w_div_last);
  assign w_step_apply = w_step_due && !w_noise_block;

  // The extra MSB is the carry/borrow: when set, the step would leave the
  // representable range, so the temperature saturates instead of wrapping.
  assign w_temp_x  = {1'b0, r_temp};
  assign w_sum_x   = w_temp_x + ONE_X;
  assign w_dif_x   = w_temp_x - ONE_X;
  assign w_temp_up = w_sum_x[TEMP_W] ? r_temp : w_sum_x[TEMP_W-1:0];
  assign w_temp_dn = w_dif_x[TEMP_W] ? r_temp : w_dif_x[TEMP_W-1:0];

  always_comb begin
    w_step_temp = r_temp;
    case (r_mode)
      MODE_HEAT: w_step_temp = w_temp_up;
      MODE_COOL: w_step_temp = w_temp_dn;
      MODE_IDLE: begin
        if (w_temp_x > AMBIENT_X) begin
          w_step_temp = w_temp_dn;
        end else if (w_temp_x < AMBIENT_X) begin
          w_step_temp = w_temp_up;
        end else begin
          w_step_temp = r_temp;
        end
      end
      default:   w_step_temp = r_temp;
    endcase
  end

  always_comb begin
    w_temp_next = r_temp;
    if (load_en) begin
      w_temp_next = load_temp;
    end else if (w_step_apply) begin
      w_temp_next = w_step_temp;
    end
  end

  // A suppressed (noise) step still restarts the prescaler, hence w_step_due.
  always_comb begin
    w_presc_next = r_presc + PRESC_W'(1);
    if (w_mode_change || load_en || (r_mode == MODE_FAULT) || w_step_due) begin
      w_presc_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= MODE_IDLE;
      r_presc      <= '0;
      r_temp       <= TEMP_W'(INIT_TEMP);
      r_temp_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_mode       <= w_mode_next;
      r_presc      <= w_presc_next;
      r_temp       <= w_temp_next;
      r_temp_valid <= (w_temp_next != r_temp);
      r_fault      <= (w_mode_next == MODE_FAULT);
    end
  end

`ifdef THERMAL_NOISE_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_fb;

  // Fibonacci LFSR, taps 8,6,5,4.
  assign w_lfsr_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_noise_block = (r_lfsr[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end
`else
  assign w_noise_block = 1'b0;
`endif

  assign temperature = r_temp;
  assign temp_valid  = r_temp_valid;
  assign fault       = r_fault;

endmodule

// File: doc/room_thermal_model.md
Name: room_thermal_model

Overview:
Synthesizable plant model for the thermostat. It is the other end of the thermostat interface: it consumes the heating/cooling demands and produces the 5-bit temperature the thermostat reads. It closes the control loop in simulation and on FPGA, so the thermostat can be exercised against a room that reacts instead of a free-running ramp.

Parameters:
TEMP_W, 5, temperature width; range 0..2^TEMP_W-1.
INIT_TEMP, 19, temperature loaded at reset.
AMBIENT, 15, temperature the room drifts toward when neither heating nor cooling is on.
HEAT_DIV, 4, clock cycles per +1 step while heating (must be >=1).
COOL_DIV, 3, clock cycles per -1 step while cooling (must be >=1).
DRIFT_DIV, 8, clock cycles per 1-step drift toward AMBIENT (must be >=1).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
heating  input  1  heater on, from the thermostat.
cooling  input  1  cooler on, from the thermostat.
load_en  input  1  force the temperature to load_temp this cycle.
load_temp  input  TEMP_W  value to force.
temperature  output  TEMP_W  current room temperature (registered).
temp_valid  output  1  one-cycle pulse on every cycle the temperature changes.
fault  output  1  high while the model is in FAULT (heating and cooling both requested).

Behaviour:
- Reset: temperature=INIT_TEMP, mode=IDLE, prescaler=0, temp_valid=0, fault=0. Reset overrides everything, including mid-step.
- Mode FSM states: IDLE, HEAT, COOL, FAULT. The registered mode follows the inputs with 1-cycle latency:
  - heating only -> HEAT
  - cooling only -> COOL
  - neither -> IDLE
  - both -> FAULT
- fault = (mode==FAULT), registered.
- Prescaler:
  - Clears to 0 on any mode change.
  - In HEAT/COOL/IDLE it counts up. When it equals DIV-1 for the current mode, a step event fires and the prescaler returns to 0.
  - First step occurs DIV cycles after the mode register is updated.
- Step effects:
  - HEAT: +1, saturating at 2^TEMP_W-1.
  - COOL: -1, saturating at 0.
  - IDLE: move 1 toward AMBIENT; no change if already equal.
  - FAULT: prescaler held at 0, temperature frozen.
- load_en: temperature=load_temp on that edge and the prescaler clears. Priority order: rst > load_en > step. Mode still updates from the inputs that same cycle.
- temp_valid: high for exactly the cycle after any edge where the temperature register value changed. This covers steps and loads. No pulse when a step saturates, when drift is already at AMBIENT, or when load_temp equals the current value.
- Arithmetic: compare and increment at TEMP_W+1 bits, so there is no wrap-around. 31+1 stays 31; 0-1 stays 0.
- Inputs are assumed synchronous to clk. There is no input synchronizer.

Optional Feature:
THERMAL_NOISE_EN:
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle. Any step event in IDLE, HEAT or COOL is suppressed when lfsr[1:0]==2'b00. On a suppressed step the prescaler still restarts and no temp_valid pulse is produced. This models irregular heat loss.
- Undefined: no LFSR exists and every step event is applied. The behaviour is fully deterministic, as specified above.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with heating=1 -> temperature=19, fault=0, temp_valid=0 throughout. Release rst -> first step to 20 exactly 5 edges later.
2. Heating: from 19 set heating=1 -> mode HEAT at edge 1, temperature 20 at edge 5, 21 at edge 9. temp_valid pulses once per step.
3. Heat saturation: load_temp=30 with load_en, heating=1 -> temperature 30 (pulse), then 31 (pulse), then holds 31 with no further pulses for 20 cycles.
4. Cooling saturation: load_temp=1, cooling=1 -> 0 after 3 cycles in COOL, then holds 0 with no pulses.
5. Idle drift: load_temp=18, heating=cooling=0 -> 17, 16, 15 at 8-cycle spacing, then holds 15. Also load 12 -> rises to 15 the same way.
6. Fault and reset mid-operation: heating=cooling=1 -> fault=1 one cycle later and temperature frozen. Drop cooling -> fault=0 one cycle later, HEAT resumes with a fresh 4-cycle prescale. Assert rst mid-prescale -> temperature=19 on the next edge.
